// File: rtl/reg_write_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// reg_write_scoreboard_pkg
// Shared types for the register-write scoreboard:
//   RegNumPath  - register-number datapath type
//   AluSelect   - ALU operand-source select encoding
//   StageEntry  - per-stage producer record {valid, wrNum, isLoad}
// Also holds small helpers that answer "does this entry write a register?"
// ---------------------------------------------------------------------------
package reg_write_scoreboard_pkg;

    localparam int REG_NUM_BITS   = 5;
    localparam int STALL_CNT_BITS = 16;

    typedef logic [REG_NUM_BITS-1:0] RegNumPath;

    // Operand source: register file, or bypass from the youngest producer
    typedef enum logic [1:0] {
        REG     = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } AluSelect;

    typedef struct packed {
        logic      valid;
        RegNumPath wrNum;
        logic      isLoad;
    } StageEntry;

    localparam StageEntry EMPTY_ENTRY = '{valid: 1'b0, wrNum: '0, isLoad: 1'b0};

    // Register 0 is hardwired, so an entry naming it never counts as a write
    function automatic logic entryWrites(StageEntry e);
        return e.valid && (e.wrNum != '0);
    endfunction

endpackage

// File: rtl/reg_write_scoreboard_src_forward_select.sv
// ---------------------------------------------------------------------------
// src_forward_select
// Picks the operand source for one ALU input by matching the source register
// against the EX, MEM and WB producer records, youngest first.
// Ports:
//   srcNum    in  source register number
//   srcUsed   in  instruction actually reads this source
//   exValid / exWrNum    in  EX producer record
//   memValid / memWrNum  in  MEM producer record
//   wbValid / wbWrNum    in  WB producer record
//   select    out 2-bit AluSelect encoding
// ---------------------------------------------------------------------------
module src_forward_select
    import reg_write_scoreboard_pkg::*;
(
    input  logic [REG_NUM_BITS-1:0] srcNum,
    input  logic                    srcUsed,
    input  logic                    exValid,
    input  logic [REG_NUM_BITS-1:0] exWrNum,
    input  logic                    memValid,
    input  logic [REG_NUM_BITS-1:0] memWrNum,
    input  logic                    wbValid,
    input  logic [REG_NUM_BITS-1:0] wbWrNum,
    output logic [1:0]              select
);

    AluSelect selValue;

    // Unused sources and r0 always read the register file. Otherwise the
    // most recently issued matching producer holds the newest value, so EX
    // beats MEM beats WB. srcNum is non-zero inside the branch, so a match
    // also implies the producer's wrNum is non-zero.
    always_comb begin
        selValue = REG;
        if (srcUsed && (srcNum != '0)) begin
            if (exValid && (exWrNum == srcNum)) begin
                selValue = FWD_EX;
            end else if (memValid && (memWrNum == srcNum)) begin
                selValue = FWD_MEM;
            end else if (wbValid && (wbWrNum == srcNum)) begin
                selValue = FWD_WB;
            end
        end
    end

    assign select = selValue;

endmodule

// File: rtl/reg_write_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_write_scoreboard
// Producer-side bookkeeping for the forwarding network. Records the
// destination of each instruction leaving ID and walks that record through
// EX, MEM and WB alongside the pipeline. From the records it derives the
// per-stage write number/enable, the ALU operand selects and the load-use
// stall, and counts stall cycles.
// Ports:
//   clk, rst (async, active-low)
//   idValid, idRsNum, idRtNum, idRsUsed, idRtUsed,
//   idWrNum, idWrEnable, idIsLoad          - instruction currently in ID
//   flush                                   - branch taken: kill ID and EX
//   stall                                   - hold front end, bubble into EX
//   aluInASelect, aluInBSelect              - operand source selects
//   wrNumToEX/MEM/WB, wrEnableToEX/MEM/WB   - tracked destination per stage
//   stallCount                              - saturating stall-cycle count
// ---------------------------------------------------------------------------
module reg_write_scoreboard
    import reg_write_scoreboard_pkg::*;
#(
    parameter int REG_NUM_W   = REG_NUM_BITS,
    parameter int STALL_CNT_W = STALL_CNT_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   idValid,
    input  logic [REG_NUM_W-1:0]   idRsNum,
    input  logic [REG_NUM_W-1:0]   idRtNum,
    input  logic                   idRsUsed,
    input  logic                   idRtUsed,
    input  logic [REG_NUM_W-1:0]   idWrNum,
    input  logic                   idWrEnable,
    input  logic                   idIsLoad,
    input  logic                   flush,
    output logic                   stall,
    output logic [1:0]             aluInASelect,
    output logic [1:0]             aluInBSelect,
    output logic [REG_NUM_W-1:0]   wrNumToEX,
    output logic [REG_NUM_W-1:0]   wrNumToMEM,
    output logic [REG_NUM_W-1:0]   wrNumToWB,
    output logic                   wrEnableToEX,
    output logic                   wrEnableToMEM,
    output logic                   wrEnableToWB,
    output logic [STALL_CNT_W-1:0] stallCount
);

    StageEntry exEntry;
    StageEntry memEntry;
    StageEntry wbEntry;
    StageEntry idRecord;

    RegNumPath rsNum;
    RegNumPath rtNum;
    logic      loadUseHit;
    logic      stallInt;
    logic      idAccept;
    logic [1:0] selA;
    logic [1:0] selB;

    assign rsNum = RegNumPath'(idRsNum);
    assign rtNum = RegNumPath'(idRtNum);

    // A non-writing instruction is recorded with wrNum 0 so that it can
    // never appear as a producer to forwarding or stall logic.
    always_comb begin
        idRecord        = EMPTY_ENTRY;
        idRecord.valid  = 1'b1;
        idRecord.wrNum  = idWrEnable ? RegNumPath'(idWrNum) : '0;
        idRecord.isLoad = idIsLoad;
    end

    // Load-use hazard: the load's data only exists at the end of MEM, so a
    // consumer directly behind it must wait one cycle. Loads already in MEM
    // or WB are served by forwarding and never stall.
    always_comb begin
        loadUseHit = 1'b0;
        if (exEntry.isLoad && entryWrites(exEntry)) begin
            loadUseHit = (idRsUsed && (rsNum == exEntry.wrNum)) ||
                         (idRtUsed && (rtNum == exEntry.wrNum));
        end
    end

    // Flush wins over stall: the dependent instruction is being killed, so
    // holding it would only waste a cycle. Reset also forces stall low.
    assign stallInt = rst && idValid && !flush && loadUseHit;
    assign idAccept = idValid && !stallInt && !flush;
    assign stall    = stallInt;

    src_forward_select selectA (
        .srcNum   (rsNum),
        .srcUsed  (idRsUsed),
        .exValid  (exEntry.valid),
        .exWrNum  (exEntry.wrNum),
        .memValid (memEntry.valid),
        .memWrNum (memEntry.wrNum),
        .wbValid  (wbEntry.valid),
        .wbWrNum  (wbEntry.wrNum),
        .select   (selA)
    );

    src_forward_select selectB (
        .srcNum   (rtNum),
        .srcUsed  (idRtUsed),
        .exValid  (exEntry.valid),
        .exWrNum  (exEntry.wrNum),
        .memValid (memEntry.valid),
        .memWrNum (memEntry.wrNum),
        .wbValid  (wbEntry.valid),
        .wbWrNum  (wbEntry.wrNum),
        .select   (selB)
    );

    // Selects fall back to the register file while reset is held so the
    // datapath sees a benign choice regardless of what ID is presenting.
    assign aluInASelect = rst ? selA : REG;
    assign aluInBSelect = rst ? selB : REG;

    // Records advance in lockstep with the pipeline. A flush kills the
    // instruction in EX, so MEM receives an empty record instead of it.
    // A stalled or killed ID slot turns into a bubble in EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exEntry  <= EMPTY_ENTRY;
            memEntry <= EMPTY_ENTRY;
            wbEntry  <= EMPTY_ENTRY;
        end else begin
            wbEntry  <= memEntry;
            memEntry <= flush ? EMPTY_ENTRY : exEntry;
            exEntry  <= idAccept ? idRecord : EMPTY_ENTRY;
        end
    end

    // Stall-cycle counter sticks at all-ones rather than wrapping, so a
    // long run reads as "at least this many" instead of a small number.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCount <= '0;
        end else if (stallInt && (stallCount != '1)) begin
            stallCount <= stallCount + STALL_CNT_W'(1);
        end
    end

    // Per-stage view for the forwarding muxes downstream.
    always_comb begin
        wrNumToEX     = REG_NUM_W'(exEntry.wrNum);
        wrNumToMEM    = REG_NUM_W'(memEntry.wrNum);
        wrNumToWB     = REG_NUM_W'(wbEntry.wrNum);
        wrEnableToEX  = entryWrites(exEntry);
        wrEnableToMEM = entryWrites(memEntry);
        wrEnableToWB  = entryWrites(wbEntry);
    end

endmodule

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
Producer-side bookkeeping for the forwarding network. It records the destination register of every instruction issued from ID and advances that record through EX, MEM and WB in lockstep with the pipeline. From those records it generates the per-stage write-number/enable signals consumed by forwarding, the ALU operand-source selects, and the load-use stall. It sits beside the ID/EX pipeline register and owns the stall/bubble decision.

Parameters:
REG_NUM_W, 5, register-number width
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
idValid  in  1  ID holds a valid instruction
idRsNum  in  REG_NUM_W  source A register
idRtNum  in  REG_NUM_W  source B register
idRsUsed  in  1  instruction reads rs
idRtUsed  in  1  instruction reads rt
idWrNum  in  REG_NUM_W  destination register
idWrEnable  in  1  instruction writes a register
idIsLoad  in  1  instruction is a load
flush  in  1  kill ID instruction and EX entry (branch taken)
stall  out  1  hold PC/IF/ID, inject bubble into EX
aluInASelect  out  2  source select for ALU A
aluInBSelect  out  2  source select for ALU B
wrNumToEX / wrNumToMEM / wrNumToWB  out  REG_NUM_W each  tracked destination per stage
wrEnableToEX / wrEnableToMEM / wrEnableToWB  out  1 each  tracked write enable per stage
stallCount  out  STALL_CNT_W  total stall cycles, saturating

Behaviour:
- Reset: rst, asynchronous, active-low; clock clk. The reset clears:
  - all stage entries (valid=0, wrNum=0, isLoad=0);
  - all wrNum*/wrEnable* outputs to 0;
  - stallCount to 0.
- While in reset, stall=0 and both selects=REG.
- Stage entry fields: valid, wrNum, isLoad. wrEnable* = valid && wrNum!=0. Register 0 is never tracked, forwarded or stalled on.
- Select encoding (shared package): REG=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
- Select priority for each source (rs→A, rt→B): youngest match wins, so EX, then MEM, then WB, else REG.
  - A source with used=0, or with number 0, always selects REG.
- Selects and stall are combinational from current entries plus ID inputs. Zero-cycle latency.
- Load-use stall: stall=1 when all of the following hold:
  - idValid && !flush;
  - EX entry is valid, isLoad=1 and wrNum!=0;
  - that wrNum equals a used source of the ID instruction.
- Load in MEM or WB does not stall; it forwards normally.
- Per-cycle update (posedge clk):
  - WB ← MEM, MEM ← EX always.
  - EX ← ID record when idValid && !stall && !flush.
  - Otherwise EX ← invalid (bubble).
- flush: the ID instruction is not recorded and the EX entry is dropped (MEM receives invalid). flush takes precedence over stall; stall is forced 0 during flush.
- Simultaneous flush and load-use match: no stall, bubble, count not incremented.
- stallCount: +1 on each cycle with stall=1. Holds at all-ones and never wraps.
- Back-to-back loads to the same register: each stalls independently, one cycle per dependent consumer.
- Reset mid-operation: all entries are discarded immediately; no partial retire.

Decomposition:
- Shared package (Types): RegNumPath width, the ALU-select enum (REG/FWD_EX/FWD_MEM/FWD_WB), and the stage-entry struct {valid, wrNum, isLoad}.
- One natural sub-module, src_forward_select: combinational priority match of one source number against three entries, returning the 2-bit select. It is instantiated twice (A and B).

Test Plan:
- Reset, then no instructions → all wrEnable*=0, selects=REG, stall=0, stallCount=0.
- add r3 then sub r4,r3,r5 next cycle → aluInASelect=FWD_EX, stall=0. One cycle later a reader of r3 gets FWD_MEM; one more cycle later it gets FWD_WB.
- lw r2 then add r6,r2,r2 → stall=1 for exactly one cycle, with bubble in EX (wrEnableToEX=0). Next cycle both selects=FWD_MEM, stall=0, stallCount=1.
- Writers to r7 in EX and in WB, reader of r7 → FWD_EX (youngest-first priority).
- Write to r0, reader of r0; also an instruction with rtUsed=0 and rt matching an EX load → selects=REG, stall=0.
- lw r2 in EX, dependent in ID, flush=1 → stall=0, EX and MEM entries invalid next cycle, stallCount unchanged. Separately, force 2^16+3 stall cycles and check stallCount=0xFFFF.
